// File: rtl/ewm_gate_tile_sched_pkg.sv
// Shared types, default widths and config helpers for the output-gate sequencing control.
package ewm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_TILE_CNT_W = 8;
    localparam int DEF_TOK_CNT_W  = 12;

    // A zero tile/token count would describe an empty run; it is treated as one.
    function automatic logic [31:0] sat_cfg(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/ewm_gate_tile_sched_if.sv
// Handshake bundle between the g/s producers, the gate datapath, the y consumer and the scheduler.
interface ewm_gate_tile_sched_if
    import ewm_ctrl_pkg::*;
#(
    parameter int TILE_CNT_W = DEF_TILE_CNT_W,
    parameter int TOK_CNT_W  = DEF_TOK_CNT_W
);
    logic                  g_valid_i;
    logic                  g_ready_o;
    logic                  g_valid_o;
    logic                  g_ready_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic                  s_valid_o;
    logic                  s_ready_i;
    logic                  y_valid_i;
    logic                  y_ready_i;
    logic                  y_ready_o;
    logic                  y_valid_o;
    logic [TILE_CNT_W-1:0] y_tile_idx;
    logic [TOK_CNT_W-1:0]  y_tok_idx;
    logic                  y_last_tile;
    logic                  y_last_run;

    // Environment side: producers, datapath and downstream consumer.
    modport master (
        output g_valid_i, g_ready_i, s_valid_i, s_ready_i, y_valid_i, y_ready_i,
        input  g_ready_o, g_valid_o, s_ready_o, s_valid_o, y_ready_o, y_valid_o,
        input  y_tile_idx, y_tok_idx, y_last_tile, y_last_run
    );

    // Scheduler side.
    modport slave (
        input  g_valid_i, g_ready_i, s_valid_i, s_ready_i, y_valid_i, y_ready_i,
        output g_ready_o, g_valid_o, s_ready_o, s_valid_o, y_ready_o, y_valid_o,
        output y_tile_idx, y_tok_idx, y_last_tile, y_last_run
    );

endinterface

// File: rtl/ewm_gate_tile_sched_tile_tok_counter.sv
// Tile/token position counter: tile wraps at num_tiles-1 and carries into the token count.
module tile_tok_counter
    import ewm_ctrl_pkg::*;
#(
    parameter int TILE_CNT_W = DEF_TILE_CNT_W,
    parameter int TOK_CNT_W  = DEF_TOK_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  adv,
    input  logic [TILE_CNT_W-1:0] num_tiles,
    input  logic [TOK_CNT_W-1:0]  num_tokens,
    output logic [TILE_CNT_W-1:0] tile_idx,
    output logic [TOK_CNT_W-1:0]  tok_idx,
    output logic                  last_tile,
    output logic                  last_run
);

    assign last_tile = (tile_idx == num_tiles - TILE_CNT_W'(1));
    assign last_run  = last_tile && (tok_idx == num_tokens - TOK_CNT_W'(1));

    // NOTE: reset is sampled on the clock edge (synchronous), and all state uses <= so every
    // flop in the design updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            tile_idx <= '0;
            tok_idx  <= '0;
        end else if (adv) begin
            if (last_tile) begin
                tile_idx <= '0;
                tok_idx  <= last_run ? '0 : tok_idx + TOK_CNT_W'(1);
            end else begin
                tile_idx <= tile_idx + TILE_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ewm_gate_tile_sched.sv
// Run sequencer for the y = s * g gate datapath: beat budget, in-flight cap, output tagging.
module ewm_gate_tile_sched
    import ewm_ctrl_pkg::*;
#(
    parameter int TILE_CNT_W   = DEF_TILE_CNT_W,
    parameter int TOK_CNT_W    = DEF_TOK_CNT_W,
    parameter int MAX_INFLIGHT = 4,
    parameter int INF_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
    input  logic [TOK_CNT_W-1:0]  cfg_num_tokens,
    output logic                  busy,
    output logic                  done,
    ewm_gate_tile_sched_if.slave  bus
);

    localparam logic [INF_W-1:0] INF_CAP = INF_W'(MAX_INFLIGHT);

    sched_state_t          state_q, state_d;
    logic [TILE_CNT_W-1:0] num_tiles_q;
    logic [TOK_CNT_W-1:0]  num_tokens_q;
    logic [INF_W-1:0]      g_inflight, s_inflight;
    logic                  g_exh_q, s_exh_q;
    logic                  g_en, s_en, g_ready, s_ready;
    logic                  g_acc, s_acc, y_acc;
    logic                  abort_hit, clr;

    logic [TILE_CNT_W-1:0] g_tile, s_tile;
    logic [TOK_CNT_W-1:0]  g_tok, s_tok;
    logic                  g_last_tile, s_last_tile, g_last_run, s_last_run;
    logic                  unused_idx;

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign abort_hit = abort && busy;
    // Counters are held clear in IDLE so every run starts from zero without a separate init step.
    assign clr       = (state_q == IDLE) || abort_hit;

    // Enables depend on registered state only, so ready never follows valid combinationally.
    assign g_en = (state_q == RUN) && !g_exh_q && (g_inflight < INF_CAP);
    assign s_en = (state_q == RUN) && !s_exh_q && (s_inflight < INF_CAP);

    assign g_ready       = bus.g_ready_i && g_en;
    assign s_ready       = bus.s_ready_i && s_en;
    assign bus.g_ready_o = g_ready;
    assign bus.s_ready_o = s_ready;
    assign bus.g_valid_o = bus.g_valid_i && g_en;
    assign bus.s_valid_o = bus.s_valid_i && s_en;
    assign g_acc         = bus.g_valid_i && g_ready;
    assign s_acc         = bus.s_valid_i && s_ready;

    assign bus.y_valid_o = bus.y_valid_i && busy;
    assign bus.y_ready_o = bus.y_ready_i && busy;
    assign y_acc         = bus.y_valid_i && busy && bus.y_ready_i;

    tile_tok_counter #(.TILE_CNT_W(TILE_CNT_W), .TOK_CNT_W(TOK_CNT_W)) u_g_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .adv(g_acc),
        .num_tiles(num_tiles_q), .num_tokens(num_tokens_q),
        .tile_idx(g_tile), .tok_idx(g_tok), .last_tile(g_last_tile), .last_run(g_last_run)
    );

    tile_tok_counter #(.TILE_CNT_W(TILE_CNT_W), .TOK_CNT_W(TOK_CNT_W)) u_s_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .adv(s_acc),
        .num_tiles(num_tiles_q), .num_tokens(num_tokens_q),
        .tile_idx(s_tile), .tok_idx(s_tok), .last_tile(s_last_tile), .last_run(s_last_run)
    );

    tile_tok_counter #(.TILE_CNT_W(TILE_CNT_W), .TOK_CNT_W(TOK_CNT_W)) u_y_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .adv(y_acc),
        .num_tiles(num_tiles_q), .num_tokens(num_tokens_q),
        .tile_idx(bus.y_tile_idx), .tok_idx(bus.y_tok_idx),
        .last_tile(bus.y_last_tile), .last_run(bus.y_last_run)
    );

    // Input-side positions only matter through their last_run flag.
    assign unused_idx = ^{g_tile, g_tok, g_last_tile, s_tile, s_tok, s_last_tile};

    function automatic logic [INF_W-1:0] infl_next(input logic [INF_W-1:0] cur,
                                                   input logic inc, input logic dec);
        logic dec_ok;
        dec_ok = dec && (cur != '0);
        case ({inc, dec_ok})
            2'b10:   return cur + INF_W'(1);
            2'b01:   return cur - INF_W'(1);
            default: return cur;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (abort)                          state_d = IDLE;
                else if (y_acc && bus.y_last_run)   state_d = DONE;
                else if (g_exh_q && s_exh_q)        state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                          state_d = IDLE;
                else if (y_acc && bus.y_last_run)   state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_tiles_q  <= TILE_CNT_W'(1);
            num_tokens_q <= TOK_CNT_W'(1);
        end else begin
            state_q <= state_d;
            if (start && (state_q == IDLE)) begin
                num_tiles_q  <= TILE_CNT_W'(sat_cfg(32'(cfg_num_tiles)));
                num_tokens_q <= TOK_CNT_W'(sat_cfg(32'(cfg_num_tokens)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            g_inflight <= '0;
            s_inflight <= '0;
            g_exh_q    <= 1'b0;
            s_exh_q    <= 1'b0;
        end else begin
            g_inflight <= infl_next(g_inflight, g_acc, y_acc);
            s_inflight <= infl_next(s_inflight, s_acc, y_acc);
            if (g_acc && g_last_run) g_exh_q <= 1'b1;
            if (s_acc && s_last_run) s_exh_q <= 1'b1;
        end
    end

    // A y beat can only exist for a g and an s beat that were already accepted.
    a_no_inflight_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        y_acc |-> (g_inflight != '0) && (s_inflight != '0));

endmodule

// File: tb/tb_ewm_gate_tile_sched.sv
// Directed bench: datapath model plus a scoreboard of expected y tags per run.
module tb_ewm_gate_tile_sched;
    import ewm_ctrl_pkg::*;

    localparam int TW   = 8;
    localparam int KW   = 12;
    localparam int MAXI = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] cfg_num_tiles = '0;
    logic [KW-1:0] cfg_num_tokens = '0;
    logic          busy, done;

    ewm_gate_tile_sched_if #(.TILE_CNT_W(TW), .TOK_CNT_W(KW)) bus ();

    ewm_gate_tile_sched #(
        .TILE_CNT_W(TW), .TOK_CNT_W(KW), .MAX_INFLIGHT(MAXI), .INF_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_num_tokens(cfg_num_tokens),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tile;
        logic [KW-1:0] tok;
        logic          lt;
        logic          lr;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    g_acc_n, s_acc_n, y_n, done_n, max_lead;
    int    cyc_n = 0;
    int    final_cyc = -100;
    bit    skew = 1'b0;

    // Gate datapath model: pairs g and s beats, offers a y beat once both are present.
    int   dp_g = 0;
    int   dp_s = 0;
    logic dp_flush = 1'b0;
    logic dp_pop;
    assign bus.y_valid_i = (dp_g > 0) && (dp_s > 0);
    assign dp_pop        = bus.y_valid_i && bus.y_ready_o;

    always @(posedge clk) begin
        if (!rst_n || dp_flush) begin
            dp_g <= 0;
            dp_s <= 0;
        end else begin
            dp_g <= dp_g + ((bus.g_valid_o && bus.g_ready_i) ? 1 : 0) - (dp_pop ? 1 : 0);
            dp_s <= dp_s + ((bus.s_valid_o && bus.s_ready_i) ? 1 : 0) - (dp_pop ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed no event expected event", tag);
    endtask

    // Observe the handshakes that the coming edge will complete, then advance one cycle.
    task automatic cyc();
        beat_t e;
        if (bus.g_valid_i && bus.g_ready_o) g_acc_n++;
        if (bus.s_valid_i && bus.s_ready_o) s_acc_n++;
        if (g_acc_n - s_acc_n > max_lead) max_lead = g_acc_n - s_acc_n;
        if (bus.y_valid_o && bus.y_ready_i) begin
            y_n++;
            if (exp_q.size() == 0) begin
                fail_now("y_beat_beyond_budget");
            end else begin
                e = exp_q.pop_front();
                check("y_tile_idx", 32'(bus.y_tile_idx), 32'(e.tile));
                check("y_tok_idx", 32'(bus.y_tok_idx), 32'(e.tok));
                check("y_last_tile", 32'(bus.y_last_tile), 32'(e.lt));
                check("y_last_run", 32'(bus.y_last_run), 32'(e.lr));
            end
            if (bus.y_last_run) final_cyc = cyc_n;
        end
        if (done) begin
            done_n++;
            check("done_latency", 32'(cyc_n - final_cyc), 32'd1);
            check("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic push_run(input int nt, input int nk);
        beat_t b;
        int    te, ke;
        te = (nt == 0) ? 1 : nt;
        ke = (nk == 0) ? 1 : nk;
        for (int k = 0; k < ke; k++) begin
            for (int t = 0; t < te; t++) begin
                b.tile = TW'(t);
                b.tok  = KW'(k);
                b.lt   = (t == te - 1);
                b.lr   = (t == te - 1) && (k == ke - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic start_run(input int nt, input int nk);
        cfg_num_tiles  = TW'(nt);
        cfg_num_tokens = KW'(nk);
        push_run(nt, nk);
        g_acc_n = 0; s_acc_n = 0; y_n = 0; done_n = 0; max_lead = 0; final_cyc = -100;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done_n == 0 && n < budget) begin
            bus.s_valid_i = skew ? (cyc_n % 3 == 0) : 1'b1;
            cyc();
            n++;
        end
        if (done_n == 0) fail_now({tag, "_done_timeout"});
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.g_valid_i = 1'b1;
        bus.s_valid_i = 1'b1;
        bus.g_ready_i = 1'b1;
        bus.s_ready_i = 1'b1;
        bus.y_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_g_ready_o", 32'(bus.g_ready_o), 32'd0);
        check("rst_g_valid_o", 32'(bus.g_valid_o), 32'd0);
        check("rst_s_ready_o", 32'(bus.s_ready_o), 32'd0);
        check("rst_y_valid_o", 32'(bus.y_valid_o), 32'd0);
        check("rst_y_tile_idx", 32'(bus.y_tile_idx), 32'd0);
        check("rst_y_tok_idx", 32'(bus.y_tok_idx), 32'd0);
        check("rst_y_last_tile", 32'(bus.y_last_tile), 32'd1);
        check("rst_y_last_run", 32'(bus.y_last_run), 32'd1);
        rst_n = 1'b1;
        cyc();

        // Nominal 4 x 3
        start_run(4, 3);
        run_until_done(200, "nominal");
        check("nom_g_accepts", 32'(g_acc_n), 32'd12);
        check("nom_s_accepts", 32'(s_acc_n), 32'd12);
        check("nom_y_beats", 32'(y_n), 32'd12);
        check("nom_done_count", 32'(done_n), 32'd1);
        check("nom_sb_empty", 32'(exp_q.size()), 32'd0);

        // In-flight cap with y stalled; start immediately follows the previous done
        bus.y_ready_i = 1'b0;
        start_run(4, 3);
        repeat (10) cyc();
        check("cap_g_accepts", 32'(g_acc_n), 32'(MAXI));
        check("cap_s_accepts", 32'(s_acc_n), 32'(MAXI));
        check("cap_g_ready_o", 32'(bus.g_ready_o), 32'd0);
        check("cap_s_ready_o", 32'(bus.s_ready_o), 32'd0);
        check("cap_busy", 32'(busy), 32'd1);
        bus.y_ready_i = 1'b1;
        cyc();
        check("cap_resume_g_ready", 32'(bus.g_ready_o), 32'd1);
        check("cap_resume_s_ready", 32'(bus.s_ready_o), 32'd1);
        run_until_done(200, "cap");
        check("cap_g_total", 32'(g_acc_n), 32'd12);
        check("cap_s_total", 32'(s_acc_n), 32'd12);
        check("cap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Skewed sides: s offered every third cycle
        skew = 1'b1;
        start_run(4, 3);
        run_until_done(400, "skew");
        skew = 1'b0;
        bus.s_valid_i = 1'b1;
        check("skew_g_total", 32'(g_acc_n), 32'd12);
        check("skew_s_total", 32'(s_acc_n), 32'd12);
        check("skew_lead_within_cap", 32'(max_lead <= MAXI), 32'd1);
        check("skew_y_beats", 32'(y_n), 32'd12);

        // Abort after 5 y beats
        start_run(4, 3);
        n = 0;
        while (y_n < 5 && n < 100) begin
            cyc();
            n++;
        end
        if (y_n < 5) fail_now("abort_wait_5_beats");
        abort = 1'b1;
        dp_flush = 1'b1;
        cyc();
        abort = 1'b0;
        dp_flush = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_g_ready_o", 32'(bus.g_ready_o), 32'd0);
        check("abort_s_ready_o", 32'(bus.s_ready_o), 32'd0);
        check("abort_g_valid_o", 32'(bus.g_valid_o), 32'd0);
        check("abort_s_valid_o", 32'(bus.s_valid_o), 32'd0);
        check("abort_y_ready_o", 32'(bus.y_ready_o), 32'd0);
        check("abort_y_tile_idx", 32'(bus.y_tile_idx), 32'd0);
        check("abort_y_tok_idx", 32'(bus.y_tok_idx), 32'd0);
        repeat (3) cyc();
        check("abort_no_done", 32'(done_n), 32'd0);
        start_run(2, 1);
        run_until_done(100, "post_abort");
        check("post_abort_y_beats", 32'(y_n), 32'd2);
        check("post_abort_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero cfg, then a start while busy that must be ignored
        start_run(0, 0);
        cfg_num_tiles  = TW'(5);
        cfg_num_tokens = KW'(5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until_done(100, "zero_cfg");
        check("zero_g_accepts", 32'(g_acc_n), 32'd1);
        check("zero_s_accepts", 32'(s_acc_n), 32'd1);
        check("zero_y_beats", 32'(y_n), 32'd1);
        check("zero_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) cyc();
        check("zero_idle_busy", 32'(busy), 32'd0);
        check("zero_idle_g_accepts", 32'(g_acc_n), 32'd1);

        // Synchronous reset during DRAIN
        bus.y_ready_i = 1'b0;
        start_run(2, 1);
        repeat (6) cyc();
        check("drain_state", 32'(dut.state_q), 32'(DRAIN));
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_g_ready_o", 32'(bus.g_ready_o), 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.y_ready_i = 1'b1;
        exp_q.delete();
        check("rrst_busy", 32'(busy), 32'd0);
        check("rrst_done", 32'(done), 32'd0);
        check("rrst_y_valid_o", 32'(bus.y_valid_o), 32'd0);
        check("rrst_y_ready_o", 32'(bus.y_ready_o), 32'd0);
        check("rrst_g_ready_o", 32'(bus.g_ready_o), 32'd0);
        check("rrst_y_tile_idx", 32'(bus.y_tile_idx), 32'd0);
        check("rrst_y_last_run", 32'(bus.y_last_run), 32'd1);
        check("rrst_g_inflight", 32'(dut.g_inflight), 32'd0);
        check("rrst_s_inflight", 32'(dut.s_inflight), 32'd0);

        // Recovery run after reset
        start_run(3, 2);
        run_until_done(200, "recover");
        check("recover_y_beats", 32'(y_n), 32'd6);
        check("recover_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
